fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles REQ may wait for imem_ready before faulting (range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetch_start  input  1  one-cycle pulse from control FSM requesting the next instruction.
REQ-006 pc_load  input  1  load pc_next into PC (jump/branch taken).
REQ-007 pc_next  input  32  target PC for pc_load.
REQ-008 imem_req  output  1  instruction-memory request, registered.
REQ-009 imem_addr  output  32  request address, registered.
REQ-010 imem_ready  input  1  memory accepts request and returns data in the same cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-012 ir  output  32  instruction register.
REQ-013 opcode  output  7  ir[6:0], feeds control FSM.
REQ-014 fun3  output  3  ir[14:12], feeds control FSM.
REQ-015 pc  output  32  current fetch PC.
REQ-016 pc_ir  output  32  address the instruction in ir was fetched from (for AUIPC/branch/JAL).
REQ-017 ir_valid  output  1  ir holds a freshly fetched word since the last fetch_start.
REQ-018 busy  output  1  high in REQ state.
REQ-019 fault  output  2  00 none, 01 misaligned PC, 10 memory timeout.

Function
REQ-020 States IDLE, REQ, FAULT; encoding free; FAULT is sticky until rst.
REQ-021 IDLE + fetch_start with pc[1:0]==0: next cycle REQ, imem_req=1, imem_addr=pc, ir_valid=0, wait counter=0.
REQ-022 IDLE + fetch_start with pc[1:0]!=0: next cycle FAULT, fault=01, no request issued.
REQ-023 REQ: imem_req and imem_addr held stable until the cycle imem_ready=1.
REQ-024 REQ + imem_ready: at that edge ir<=imem_rdata, pc_ir<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), ir_valid<=1, imem_req<=0, state<=IDLE.
REQ-025 Fetch latency: ir_valid rises 2 cycles after fetch_start with imem_ready tied high; each additional wait cycle adds one.
REQ-026 REQ without imem_ready: wait counter increments; when it reaches TIMEOUT without ready, next state FAULT, fault=10, imem_req=0.
REQ-027 fetch_start in REQ or FAULT: ignored.
REQ-028 pc_load in IDLE: pc<=pc_next next edge; ir, pc_ir, ir_valid unchanged.
REQ-029 pc_load and fetch_start same cycle in IDLE: pc_load wins for PC; fetch uses pc_next (alignment checked on pc_next; imem_addr=pc_next).
REQ-030 pc_load in REQ: pc_next latched into a pending register; on capture pc<=pending value instead of pc+4; imem_addr of the in-flight request unchanged.
REQ-031 Multiple pc_load in REQ: last one wins; pending cleared on capture.
REQ-032 pc_load in FAULT: ignored.
REQ-033 opcode and fun3 combinational slices of ir; no other combinational input-to-output paths.

Reset
REQ-034 rst=1 at an edge, from any state: state=IDLE, pc=RESET_PC, pc_ir=0, ir=0 (opcode 0 = NoOp), ir_valid=0, imem_req=0, imem_addr=0, fault=00, pending and wait counter cleared.
REQ-035 rst during REQ abandons the request; a late imem_ready after reset is ignored.

Verification
REQ-036 Reset, fetch_start, imem_ready=1, rdata=32'h0000_0093 -> cycle 2: ir=32'h0000_0093, opcode=7'b0010011, fun3=0, pc_ir=0, pc=4, ir_valid=1.
REQ-037 fetch_start, imem_ready low 3 cycles then high, rdata=32'h00A5_8463 -> imem_addr stable 4 cycles, busy 4 cycles, opcode=7'b1100011, fun3=3'b000.
REQ-038 pc_load pc_next=32'h0000_0102 in IDLE, then fetch_start -> fault=01 next cycle, imem_req never asserted; further fetch_start ignored until rst.
REQ-039 TIMEOUT=4, fetch_start, imem_ready held 0 -> fault=10 and imem_req=0 after 4 wait cycles; rst -> fault=00, pc=RESET_PC.
REQ-040 During REQ pulse pc_load pc_next=32'h0000_0040 then 32'h0000_0080, ready later -> pc=32'h0000_0080, pc_ir=old pc, imem_addr unchanged during REQ.
REQ-041 pc=32'hFFFF_FFFC, fetch completes -> pc=32'h0000_0000, pc_ir=32'hFFFF_FFFC; rst asserted mid-REQ then imem_ready=1 -> ir=0, ir_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
// Memory accepts a request and returns its data in the same cycle that imem_ready is high.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory request per fetch_start,
// captures the returned word into ir and reports misalignment or memory timeout.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   fetch_unit_if.master imem,
   output logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  fun3,
   output logic [31:0] pc,
   output logic [31:0] pc_ir,
   output logic        ir_valid,
   output logic        busy,
   output logic [1:0]  fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] pend_pc;
   logic        pend_valid;
   logic [31:0] start_pc;

   // A jump arriving together with fetch_start redirects that very fetch.
   assign start_pc = pc_load ? pc_next : pc;

   assign opcode = ir[6:0];
   assign fun3   = ir[14:12];
   assign busy   = (state == REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         pc_ir          <= 32'h0000_0000;
         ir             <= 32'h0000_0000;
         ir_valid       <= 1'b0;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= 32'h0000_0000;
         fault          <= 2'b00;
         wait_cnt       <= 8'd0;
         pend_pc        <= 32'h0000_0000;
         pend_valid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pc_load) begin
                  pc <= pc_next;
               end
               if (fetch_start) begin
                  ir_valid <= 1'b0;
                  if (start_pc[1:0] == 2'b00) begin
                     state          <= REQ;
                     imem.imem_req  <= 1'b1;
                     imem.imem_addr <= start_pc;
                     wait_cnt       <= 8'd0;
                     pend_valid     <= 1'b0;
                  end else begin
                     state <= FAULT;
                     fault <= 2'b01;
                  end
               end
            end

            REQ: begin
               if (imem.imem_ready) begin
                  // The newest redirect wins; otherwise fall through to the next word.
                  ir            <= imem.imem_rdata;
                  pc_ir         <= pc;
                  pc            <= pc_load ? pc_next : (pend_valid ? pend_pc : pc + 32'd4);
                  ir_valid      <= 1'b1;
                  imem.imem_req <= 1'b0;
                  pend_valid    <= 1'b0;
                  state         <= IDLE;
               end else begin
                  if (pc_load) begin
                     pend_pc    <= pc_next;
                     pend_valid <= 1'b1;
                  end
                  if (wait_cnt == TIMEOUT_LAST) begin
                     state         <= FAULT;
                     fault         <= 2'b10;
                     imem.imem_req <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
            end

            FAULT: begin
               state <= FAULT;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TIMEOUT  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_load;
   logic [31:0] pc_next;
   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [2:0]  fun3;
   logic [31:0] pc;
   logic [31:0] pc_ir;
   logic        ir_valid;
   logic        busy;
   logic [1:0]  fault;

   int total = 0;
   int bad   = 0;

   // Model state: architectural view after each completed transaction.
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   logic [31:0] m_pc_ir;
   logic        m_valid;
   logic [1:0]  m_fault;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_load     (pc_load),
      .pc_next     (pc_next),
      .imem        (bus),
      .ir          (ir),
      .opcode      (opcode),
      .fun3        (fun3),
      .pc          (pc),
      .pc_ir       (pc_ir),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_next = '0;
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      m_pc = RESET_PC; m_ir = '0; m_pc_ir = '0; m_valid = 1'b0; m_fault = 2'b00;
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00;
      return r;
   endfunction

   // Pulses fetch_start, then serves the request: ready after 'waits' stall cycles,
   // optionally redirecting with pc_load during the request. Observes only.
   task automatic run_fetch(input logic [31:0] rdata, input int waits, input int load_pct,
                            output int busy_n, output bit addr_stable, output logic [31:0] first_addr,
                            output bit loaded, output logic [31:0] load_val);
      busy_n = 0; addr_stable = 1'b1; first_addr = 'x; loaded = 1'b0; load_val = '0;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      for (int i = 0; i < TIMEOUT + 2; i++) begin
         if (busy !== 1'b1) break;
         busy_n++;
         if (i == 0) first_addr = bus.imem_addr;
         else if (bus.imem_addr !== first_addr || bus.imem_req !== 1'b1) addr_stable = 1'b0;
         bus.imem_ready = (i == waits);
         bus.imem_rdata = (i == waits) ? rdata : $urandom();
         if (int'($urandom_range(0, 99)) < load_pct) begin
            pc_load = 1'b1; pc_next = rand_target(); loaded = 1'b1; load_val = pc_next;
         end
         tick();
         pc_load = 1'b0; bus.imem_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
      total++; if (ir !== 32'h0) begin bad++; $display("[TB] FAIL reset_ir got=%h exp=0", ir); end
      total++; if (pc_ir !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc_ir got=%h exp=0", pc_ir); end
      total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_ir_valid got=%b exp=0", ir_valid); end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b exp=0", bus.imem_req); end
      total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=0", bus.imem_addr); end
      total++; if (fault !== 2'b00) begin bad++; $display("[TB] FAIL reset_fault got=%b exp=00", fault); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0093;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL basic_req got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
      total++; if (ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_early got=%b exp=0", ir_valid); end
      tick();
      bus.imem_ready = 1'b0;
      total++; if (ir !== 32'h0000_0093) begin bad++; $display("[TB] FAIL basic_ir got=%h exp=00000093", ir); end
      total++; if (opcode !== 7'b0010011 || fun3 !== 3'b000) begin bad++; $display("[TB] FAIL basic_decode got=%b/%b exp=0010011/000", opcode, fun3); end
      total++; if (pc_ir !== 32'h0 || pc !== 32'h4) begin bad++; $display("[TB] FAIL basic_pc got=%h/%h exp=0/4", pc_ir, pc); end
      total++; if (ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL basic_done got=%b/%b exp=1/0", ir_valid, bus.imem_req); end
   endtask

   task automatic test_wait_states();
      int n; bit stable, ld; logic [31:0] a0, lv;
      run_fetch(32'h00A5_8463, 3, 0, n, stable, a0, ld, lv);
      total++; if (n !== 4) begin bad++; $display("[TB] FAIL wait_busy got=%0d exp=4", n); end
      total++; if (!stable || a0 !== 32'h4) begin bad++; $display("[TB] FAIL wait_addr got=%h stable=%b exp=4", a0, stable); end
      total++; if (opcode !== 7'b1100011 || fun3 !== 3'b000) begin bad++; $display("[TB] FAIL wait_decode got=%b/%b exp=1100011/000", opcode, fun3); end
      total++; if (pc !== 32'h8 || pc_ir !== 32'h4) begin bad++; $display("[TB] FAIL wait_pc got=%h/%h exp=8/4", pc, pc_ir); end
   endtask

   task automatic test_load_with_start();
      pc_load = 1'b1; pc_next = 32'h0000_0200; fetch_start = 1'b1;
      tick();
      pc_load = 1'b0; fetch_start = 1'b0;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("[TB] FAIL ldstart_req got=%b/%h exp=1/200", bus.imem_req, bus.imem_addr); end
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678;
      tick();
      bus.imem_ready = 1'b0;
      total++; if (pc !== 32'h204 || pc_ir !== 32'h200) begin bad++; $display("[TB] FAIL ldstart_pc got=%h/%h exp=204/200", pc, pc_ir); end
   endtask

   task automatic test_misaligned();
      bit req_seen;
      pc_load = 1'b1; pc_next = 32'h0000_0102;
      tick();
      pc_load = 1'b0;
      total++; if (pc !== 32'h102) begin bad++; $display("[TB] FAIL mis_load_pc got=%h exp=102", pc); end
      total++; if (ir !== 32'h1234_5678 || pc_ir !== 32'h200 || ir_valid !== 1'b1) begin bad++; $display("[TB] FAIL mis_load_keep got=%h/%h/%b exp=12345678/200/1", ir, pc_ir, ir_valid); end
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      total++; if (fault !== 2'b01 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mis_fault got=%b/%b exp=01/0", fault, busy); end
      req_seen = bus.imem_req;
      for (int i = 0; i < 6; i++) begin
         fetch_start = i[0]; pc_load = ~i[0]; pc_next = 32'h0000_0300; bus.imem_ready = 1'b1;
         tick();
         if (bus.imem_req === 1'b1) req_seen = 1'b1;
      end
      fetch_start = 1'b0; pc_load = 1'b0; bus.imem_ready = 1'b0;
      total++; if (req_seen !== 1'b0) begin bad++; $display("[TB] FAIL mis_no_req got=%b exp=0", req_seen); end
      total++; if (fault !== 2'b01 || pc !== 32'h102) begin bad++; $display("[TB] FAIL mis_sticky got=%b/%h exp=01/102", fault, pc); end
      do_reset();
      total++; if (fault !== 2'b00 || pc !== RESET_PC) begin bad++; $display("[TB] FAIL mis_reset got=%b/%h exp=00/%h", fault, pc, RESET_PC); end
   endtask

   task automatic test_timeout();
      int n; bit stable, ld; logic [31:0] a0, lv;
      do_reset();
      run_fetch(32'hDEAD_BEEF, TIMEOUT, 0, n, stable, a0, ld, lv);
      total++; if (n !== TIMEOUT) begin bad++; $display("[TB] FAIL tmo_busy got=%0d exp=%0d", n, TIMEOUT); end
      total++; if (fault !== 2'b10 || bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL tmo_fault got=%b/%b exp=10/0", fault, bus.imem_req); end
      run_fetch(32'h0, 0, 0, n, stable, a0, ld, lv);
      total++; if (n !== 0 || fault !== 2'b10) begin bad++; $display("[TB] FAIL tmo_ignore got=%0d/%b exp=0/10", n, fault); end
      do_reset();
      total++; if (fault !== 2'b00 || pc !== RESET_PC) begin bad++; $display("[TB] FAIL tmo_reset got=%b/%h exp=00/%h", fault, pc, RESET_PC); end
   endtask

   task automatic test_pending_load();
      int n; bit stable, ld; logic [31:0] a0, lv;
      do_reset();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      pc_load = 1'b1; pc_next = 32'h0000_0040;
      tick();
      pc_next = 32'h0000_0080;
      tick();
      pc_load = 1'b0;
      total++; if (bus.imem_addr !== 32'h0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL pend_addr got=%h/%b exp=0/1", bus.imem_addr, busy); end
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0013;
      tick();
      bus.imem_ready = 1'b0;
      total++; if (pc !== 32'h80 || pc_ir !== 32'h0) begin bad++; $display("[TB] FAIL pend_pc got=%h/%h exp=80/0", pc, pc_ir); end
      run_fetch(32'h0000_0013, 1, 0, n, stable, a0, ld, lv);
      total++; if (a0 !== 32'h80 || pc !== 32'h84) begin bad++; $display("[TB] FAIL pend_clear got=%h/%h exp=80/84", a0, pc); end
   endtask

   task automatic test_wrap_and_abort();
      int n; bit stable, ld; logic [31:0] a0, lv;
      pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
      tick();
      pc_load = 1'b0;
      run_fetch(32'h0000_0113, 1, 0, n, stable, a0, ld, lv);
      total++; if (pc !== 32'h0 || pc_ir !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc got=%h/%h exp=0/fffffffc", pc, pc_ir); end
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
      tick();
      bus.imem_ready = 1'b0;
      total++; if (ir !== 32'h0 || ir_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_ir got=%h/%b exp=0/0", ir, ir_valid); end
      total++; if (bus.imem_req !== 1'b0 || pc !== RESET_PC) begin bad++; $display("[TB] FAIL abort_state got=%b/%h exp=0/%h", bus.imem_req, pc, RESET_PC); end
   endtask

   task automatic test_random();
      int n, waits, exp_busy; bit stable, ld; logic [31:0] a0, lv, rdata, addr;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            pc_load = 1'b1; pc_next = rand_target();
            tick();
            pc_load = 1'b0;
            m_pc = pc_next;
         end
         waits = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TIMEOUT - 1)) : TIMEOUT;
         rdata = $urandom();
         run_fetch(rdata, waits, 30, n, stable, a0, ld, lv);
         addr = m_pc;
         m_valid = 1'b0;
         if (addr[1:0] != 2'b00) begin
            m_fault = 2'b01; exp_busy = 0;
         end else if (waits >= TIMEOUT) begin
            m_fault = 2'b10; exp_busy = TIMEOUT;
         end else begin
            exp_busy = waits + 1;
            m_ir = rdata; m_pc_ir = addr; m_valid = 1'b1;
            m_pc = ld ? lv : addr + 32'd4;
         end
         total++; if (n !== exp_busy) begin bad++; $display("[TB] FAIL rnd_busy it=%0d got=%0d exp=%0d", it, n, exp_busy); end
         total++; if (fault !== m_fault || ir_valid !== m_valid) begin bad++; $display("[TB] FAIL rnd_status it=%0d got=%b/%b exp=%b/%b", it, fault, ir_valid, m_fault, m_valid); end
         if (exp_busy != 0) begin
            total++; if (a0 !== addr || !stable) begin bad++; $display("[TB] FAIL rnd_addr it=%0d got=%h stable=%b exp=%h", it, a0, stable, addr); end
         end
         if (m_fault == 2'b00) begin
            total++; if (ir !== m_ir || opcode !== m_ir[6:0] || fun3 !== m_ir[14:12]) begin bad++; $display("[TB] FAIL rnd_ir it=%0d got=%h exp=%h", it, ir, m_ir); end
            total++; if (pc !== m_pc || pc_ir !== m_pc_ir) begin bad++; $display("[TB] FAIL rnd_pc it=%0d got=%h/%h exp=%h/%h", it, pc, pc_ir, m_pc, m_pc_ir); end
         end else begin
            do_reset();
         end
      end
   endtask

   initial begin
      rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_next = '0;
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      test_reset();
      test_basic_fetch();
      test_wait_states();
      test_load_with_start();
      test_misaligned();
      test_timeout();
      test_pending_load();
      test_wrap_and_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
